// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: drives the four input vectors (00,01,10,11) into a
// 2-input gate under test and compares y_in against the gate function
// selected at start. It reports a per-vector mismatch mask, a mismatch
// count, and pass/done flags.
module gate_sweep_checker #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] func_sel,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  // Counter value on the last settle edge before sampling.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  // Gate function codes.
  localparam logic [2:0] F_AND  = 3'd0;
  localparam logic [2:0] F_OR   = 3'd1;
  localparam logic [2:0] F_XOR  = 3'd2;
  localparam logic [2:0] F_NAND = 3'd3;
  localparam logic [2:0] F_NOR  = 3'd4;
  localparam logic [2:0] F_XNOR = 3'd5;
  localparam logic [2:0] F_A    = 3'd6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] k, k_nxt;
  logic [3:0] settle_cnt, settle_cnt_nxt;
  logic [2:0] func_q, func_q_nxt;
  logic [2:0] err_nxt;
  logic [3:0] fail_nxt;
  logic       exp_y;
  logic       vec_a, vec_b;

  // The vector index maps straight onto the gate inputs.
  assign vec_a = k[1];
  assign vec_b = k[0];

  // Expected gate output for the current vector under the latched function.
  always_comb begin
    exp_y = ~vec_a;
    case (func_q)
      F_AND:   exp_y = vec_a & vec_b;
      F_OR:    exp_y = vec_a | vec_b;
      F_XOR:   exp_y = vec_a ^ vec_b;
      F_NAND:  exp_y = ~(vec_a & vec_b);
      F_NOR:   exp_y = ~(vec_a | vec_b);
      F_XNOR:  exp_y = ~(vec_a ^ vec_b);
      F_A:     exp_y = vec_a;
      default: exp_y = ~vec_a;
    endcase
  end

  // Next-state and datapath updates; everything holds unless a case below
  // changes it.
  always_comb begin
    state_nxt      = state;
    k_nxt          = k;
    settle_cnt_nxt = settle_cnt;
    func_q_nxt     = func_q;
    err_nxt        = err_count;
    fail_nxt       = fail_vec;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt      = SETTLE;
          k_nxt          = 2'd0;
          settle_cnt_nxt = 4'd0;
          func_q_nxt     = func_sel;
          err_nxt        = 3'd0;
          fail_nxt       = 4'd0;
        end
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_nxt      = SAMPLE;
          settle_cnt_nxt = 4'd0;
        end else begin
          settle_cnt_nxt = settle_cnt + 4'd1;
        end
      end
      SAMPLE: begin
        if (y_in != exp_y) begin
          // At most four vectors, so the count tops out at 4; the guard
          // still keeps it from wrapping.
          if (err_count != 3'd4) err_nxt = err_count + 3'd1;
          fail_nxt[k] = 1'b1;
        end
        settle_cnt_nxt = 4'd0;
        if (k == 2'd3) begin
          state_nxt = DONE;
        end else begin
          k_nxt     = k + 2'd1;
          state_nxt = SETTLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers; reset clears all of them immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      k          <= 2'd0;
      settle_cnt <= 4'd0;
      func_q     <= 3'd0;
      err_count  <= 3'd0;
      fail_vec   <= 4'd0;
    end else begin
      state      <= state_nxt;
      k          <= k_nxt;
      settle_cnt <= settle_cnt_nxt;
      func_q     <= func_q_nxt;
      err_count  <= err_nxt;
      fail_vec   <= fail_nxt;
    end
  end

  // Outputs decode from state. The gate inputs are parked at 00 whenever
  // no sweep is in progress.
  always_comb begin
    busy  = (state == SETTLE) || (state == SAMPLE);
    done  = (state == DONE);
    pass  = done && (err_count == 3'd0);
    a_out = busy & vec_a;
    b_out = busy & vec_b;
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Scoreboard bench for gate_sweep_checker: the stimulus pushes the expected
// result of each sweep, and a monitor pops and checks it when done rises.
module tb_gate_sweep_checker;
  localparam int S   = 2;
  localparam int LAT = 4 * (S + 1);
  // Vector sequence seen on a_out/b_out over one sweep, first cycle in the MSBs.
  localparam logic [23:0] EXP_SEQ = 24'b00_00_00_01_01_01_10_10_10_11_11_11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] func_sel = 3'd0;
  logic       y_in;
  logic       a_out, b_out, busy, done, pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;

  // y_mode: 0 gate model, 1 tied 0, 2 tied 1, 3 inverted gate model
  logic [1:0] y_mode = 2'd0;
  logic [2:0] tb_func = 3'd0;

  typedef struct {
    logic [2:0] err;
    logic [3:0] fail;
    logic       pass;
    int         acc;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int passed = 0;
  int edge_cnt = 0;

  gate_sweep_checker #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .func_sel(func_sel), .y_in(y_in),
    .a_out(a_out), .b_out(b_out), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_vec(fail_vec)
  );

  always #5 clk = ~clk;

  // Gate under test model.
  function automatic logic gate(input logic [2:0] f, input logic a, input logic b);
    case (f)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return ~(a ^ b);
      3'd6: return a;
      default: return ~a;
    endcase
  endfunction

  always_comb begin
    y_in = 1'b0;
    case (y_mode)
      2'd0: y_in = gate(tb_func, a_out, b_out);
      2'd1: y_in = 1'b0;
      2'd2: y_in = 1'b1;
      default: y_in = ~gate(tb_func, a_out, b_out);
    endcase
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  // Monitor: captures the driven vectors and checks results on done rising.
  initial begin
    logic [23:0] seq;
    int          n;
    logic        busy_q, done_q;
    exp_t        e;
    seq = '0; n = 0; busy_q = 1'b0; done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (busy) begin
        if (!busy_q) begin
          seq = '0;
          n = 0;
        end
        seq = {seq[21:0], a_out, b_out};
        n++;
      end
      if (done && !done_q) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: got done=1 expected no sweep pending");
        end else begin
          e = sb.pop_front();
          check("err_count", 32'(err_count), 32'(e.err));
          check("fail_vec", 32'(fail_vec), 32'(e.fail));
          check("pass", 32'(pass), 32'(e.pass));
          check("latency", 32'(edge_cnt - e.acc), 32'(LAT));
          check("vec_cycles", 32'(n), 32'(LAT));
          check("vec_seq", 32'(seq), 32'(EXP_SEQ));
        end
      end
      busy_q = busy;
      done_q = done;
    end
  end

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      $display("FAIL done_timeout: got done=0 expected done=1 within 60 cycles");
    end
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [2:0] e_err, input logic [3:0] e_fail, input int acc);
    exp_t e;
    e.err = e_err;
    e.fail = e_fail;
    e.pass = (e_err == 3'd0);
    e.acc = acc;
    sb.push_back(e);
  endtask

  task automatic do_sweep(input logic [2:0] fs, input logic [1:0] mode, input logic [2:0] gfunc,
                          input logic [2:0] e_err, input logic [3:0] e_fail);
    @(negedge clk);
    func_sel = fs; tb_func = gfunc; y_mode = mode; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    push_exp(e_err, e_fail, edge_cnt);
    wait_done();
  endtask

  initial begin
    int acc;
    // Reset state, checked before any clock edge.
    #2;
    check("reset_outputs", 32'({a_out, b_out, busy, done, pass, err_count, fail_vec}), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // XOR gate, pass; then mismatch patterns, including all four vectors failing.
    do_sweep(3'b010, 2'd0, 3'b010, 3'd0, 4'b0000);
    do_sweep(3'b010, 2'd1, 3'b010, 3'd2, 4'b0110);
    do_sweep(3'b000, 2'd2, 3'b000, 3'd3, 4'b0111);
    do_sweep(3'b000, 2'd0, 3'b000, 3'd0, 4'b0000);
    do_sweep(3'b101, 2'd1, 3'b101, 3'd2, 4'b1001);
    do_sweep(3'b100, 2'd2, 3'b100, 3'd3, 4'b1110);
    do_sweep(3'b111, 2'd1, 3'b111, 3'd2, 4'b0011);
    do_sweep(3'b000, 2'd3, 3'b000, 3'd4, 4'b1111);
    check("done_hold", 32'({busy, done, a_out, b_out, err_count, fail_vec}), 32'({4'b0100, 3'd4, 4'b1111}));

    // Every function against its matching gate.
    for (int f = 0; f < 8; f++) do_sweep(3'(f), 2'd0, 3'(f), 3'd0, 4'b0000);

    // Start pulses and func_sel changes mid-sweep have no effect.
    @(negedge clk);
    func_sel = 3'b010; tb_func = 3'b010; y_mode = 2'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    push_exp(3'd0, 4'b0000, edge_cnt);
    @(posedge clk); #1; @(posedge clk); #1;
    start = 1'b1; func_sel = 3'b000;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; func_sel = 3'b111;
    wait_done();

    // Start held high: a second sweep begins on the first edge in DONE.
    @(negedge clk);
    func_sel = 3'b001; tb_func = 3'b001; y_mode = 2'd0; start = 1'b1;
    @(posedge clk); #1;
    acc = edge_cnt;
    push_exp(3'd0, 4'b0000, acc);
    while (edge_cnt < acc + LAT + 1) begin
      @(posedge clk); #1;
    end
    push_exp(3'd0, 4'b0000, acc + LAT + 1);
    check("restart_busy", 32'({busy, done}), 32'b10);
    start = 1'b0;
    wait_done();

    // Asynchronous reset during vector 2 settle.
    @(negedge clk);
    func_sel = 3'b010; tb_func = 3'b010; y_mode = 2'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    acc = edge_cnt;
    while (edge_cnt < acc + 7) begin
      @(posedge clk); #1;
    end
    check("pre_reset_state", 32'({a_out, b_out, busy, err_count, fail_vec}), 32'({3'b101, 3'd1, 4'b0010}));
    #1 rst_n = 1'b0;
    #1 check("async_reset", 32'({a_out, b_out, busy, done, pass, err_count, fail_vec}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh full sweep after reset.
    do_sweep(3'b011, 2'd0, 3'b011, 3'd0, 4'b0000);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule
